predict_grid_sequencer: RTL and testbench
=========================================

Name: predict_grid_sequencer

Overview:
- Sequences the obstacle-robot prediction-grid datapath across a horizon of future steps.
- On start, freezes a snapshot of all stepper positions, then walks `step` from 0 to `horizon-1`.
- Waits the datapath's fixed latency for each step, then hands each settled grid to the downstream collision checker via a valid/ready handshake.
- Sits between the motion/planner top level and the prediction-grid datapath.

Parameters:
- STEPPERS_NUM, 6, number of stepper axes; the position bus is 32*STEPPERS_NUM bits.
- PREDICT_LAT, 4, cycles from a new step/snapshot presented to the datapath until its grid output is settled (>=1).
- MAX_HORIZON, 255, largest accepted horizon value (<=255, fits 8 bits).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a prediction sweep; honoured only in IDLE.
- abort  in  1  terminate the sweep and return to IDLE.
- horizon  in  8  number of steps to predict; sampled with start.
- stepperPosition  in  32*STEPPERS_NUM  live stepper positions; sampled with start.
- posSnapshot  out  32*STEPPERS_NUM  frozen positions driven to the prediction datapath.
- step  out  8  step index driven to the prediction datapath.
- gridValid  out  1  grid for gridStep is settled and offered downstream.
- gridReady  in  1  downstream accepts the offered grid.
- gridStep  out  8  step index tag of the offered grid (equals step while gridValid).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the final step is accepted or the sweep is aborted.
- aborted  out  1  qualifies done; high in the same cycle when the sweep ended by abort.

Behaviour:
- Reset values (async on RST high):
  - state=IDLE.
  - posSnapshot=0, step=0, gridStep=0.
  - gridValid=0, busy=0, done=0, aborted=0.
  - wait counter=0, latched horizon=0.
- States: IDLE, SETTLE, OFFER, DONE.
- IDLE:
  - start=1 with horizon in 1..MAX_HORIZON: next cycle posSnapshot<=stepperPosition, hlat<=horizon, step<=0, wait counter<=PREDICT_LAT-1, go to SETTLE.
  - start with horizon=0 or horizon>MAX_HORIZON: no sweep; pulse done next cycle with aborted=0, stay IDLE.
- SETTLE:
  - Decrement the wait counter each cycle.
  - When the counter is 0, go to OFFER with gridValid=1.
  - With PREDICT_LAT=1, the first offer appears 2 cycles after start.
- OFFER:
  - gridValid held high; step, posSnapshot and gridStep are stable until the handshake.
  - Transfer occurs on a cycle where gridValid&&gridReady.
  - On transfer, if step==hlat-1: gridValid<=0, go to DONE.
  - Otherwise: step<=step+1, gridValid<=0, wait counter<=PREDICT_LAT-1, go to SETTLE.
  - gridValid never drops without a transfer, except on abort or reset.
- DONE: done=1 and aborted=0 for one cycle, then IDLE.
- Throughput: one grid per PREDICT_LAT+1 cycles with gridReady tied high.
- Latency: start to first gridValid = PREDICT_LAT+1 cycles.
- Step arithmetic: unsigned 8-bit; never wraps, because hlat<=255 and the last index is hlat-1<=254.
- Abort:
  - Outside IDLE, abort forces the next state to IDLE, clears gridValid, and pulses done=1 with aborted=1 next cycle.
  - posSnapshot is retained; step resets to 0.
  - Abort has priority over a same-cycle transfer: that grid is not counted, so the consumer must discard it on aborted.
  - Abort in IDLE is ignored; abort and start together in IDLE means abort wins and no sweep starts.
- start while busy: ignored, no effect on the snapshot or step.
- stepperPosition changes during a sweep: no effect; only the snapshot is used.
- gridReady while gridValid=0: ignored.
- RST mid-sweep: immediate return to reset values; no done pulse.

Test Plan:
- PREDICT_LAT=4, horizon=3, gridReady=1, start at cycle 0 -> gridValid at cycles 5, 10, 15 with gridStep 0,1,2; done=1, aborted=0 at cycle 16; busy high from cycle 1 through 16.
- Backpressure: horizon=2, gridReady low for 7 cycles after the first gridValid -> gridValid, gridStep=0 and posSnapshot held stable throughout; step 1 is offered PREDICT_LAT+1 cycles after the transfer.
- Snapshot freeze: start with axis0=0x00001000, then change stepperPosition every cycle -> posSnapshot stays 0x00001000 for the whole sweep; a second start while busy is ignored.
- Abort during OFFER at step 1 of horizon 5, with gridReady=1 the same cycle -> next cycle gridValid=0, done=1, aborted=1, step=0, state IDLE; no further offers.
- horizon=0 start -> done pulse with aborted=0 and no gridValid; horizon=255 -> 255 offers, last gridStep=254, no wrap.
- Assert RST in SETTLE of step 3 -> all outputs at reset values asynchronously, no done pulse; a fresh start after release behaves as in the first scenario.

Source files
------------

// File: rtl/predict_grid_sequencer.sv
// Prediction-grid sweep sequencer: snapshots stepper positions, walks the step
// index over the horizon and offers each settled grid downstream.
module predict_grid_sequencer #(
    parameter int STEPPERS_NUM = 6,
    parameter int PREDICT_LAT  = 4,
    parameter int MAX_HORIZON  = 255
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic                      abort,
    input  logic [7:0]                horizon,
    input  logic [32*STEPPERS_NUM-1:0] stepperPosition,
    output logic [32*STEPPERS_NUM-1:0] posSnapshot,
    output logic [7:0]                step,
    output logic                      gridValid,
    input  logic                      gridReady,
    output logic [7:0]                gridStep,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted
);

    localparam int CW = (PREDICT_LAT > 1) ? $clog2(PREDICT_LAT) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(PREDICT_LAT - 1);
    localparam logic [8:0] MAX_H = 9'(MAX_HORIZON);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        OFFER,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [7:0]      hlat;
    logic            horizon_ok;
    logic            last_step;
    logic            transfer;

    assign horizon_ok = (horizon != 8'd0) && ({1'b0, horizon} <= MAX_H);
    assign last_step  = (step == hlat - 8'd1);
    assign transfer   = gridValid && gridReady;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            posSnapshot <= '0;
            step        <= '0;
            gridStep    <= '0;
            gridValid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            wait_cnt    <= '0;
            hlat        <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            // Abort wins over any same-cycle handshake; that grid is dropped.
            if (abort && state != IDLE) begin
                state     <= IDLE;
                gridValid <= 1'b0;
                step      <= '0;
                wait_cnt  <= '0;
                busy      <= 1'b0;
                done      <= 1'b1;
                aborted   <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            if (horizon_ok) begin
                                posSnapshot <= stepperPosition;
                                hlat        <= horizon;
                                step        <= '0;
                                wait_cnt    <= LAT_M1;
                                busy        <= 1'b1;
                                state       <= SETTLE;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    SETTLE: begin
                        if (wait_cnt == '0) begin
                            gridValid <= 1'b1;
                            gridStep  <= step;
                            state     <= OFFER;
                        end else begin
                            wait_cnt <= wait_cnt - CW'(1);
                        end
                    end
                    OFFER: begin
                        if (transfer) begin
                            gridValid <= 1'b0;
                            if (last_step) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                step     <= step + 8'd1;
                                wait_cnt <= LAT_M1;
                                state    <= SETTLE;
                            end
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_predict_grid_sequencer.sv
// Directed bench for predict_grid_sequencer with hand-computed cycle timings
// (PREDICT_LAT=4: offers every 5 cycles, first offer 5 cycles after start).
module tb_predict_grid_sequencer;

    localparam int SN = 6;
    localparam int PW = 32 * SN;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic          abort;
    logic [7:0]    horizon;
    logic [PW-1:0] stepperPosition;
    logic [PW-1:0] posSnapshot;
    logic [7:0]    step;
    logic          gridValid;
    logic          gridReady;
    logic [7:0]    gridStep;
    logic          busy;
    logic          done;
    logic          aborted;

    int checks = 0;
    int errors = 0;

    predict_grid_sequencer #(
        .STEPPERS_NUM(SN),
        .PREDICT_LAT (4),
        .MAX_HORIZON (255)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .start          (start),
        .abort          (abort),
        .horizon        (horizon),
        .stepperPosition(stepperPosition),
        .posSnapshot    (posSnapshot),
        .step           (step),
        .gridValid      (gridValid),
        .gridReady      (gridReady),
        .gridStep       (gridStep),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [PW-1:0] got,
                         input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_sweep(input logic [7:0] h, input logic [PW-1:0] pos);
        start           = 1'b1;
        horizon         = h;
        stepperPosition = pos;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_snap"}, posSnapshot, '0);
        check({tag, "_step"}, PW'(step), '0);
        check({tag, "_gstep"}, PW'(gridStep), '0);
        check({tag, "_valid"}, PW'(gridValid), '0);
        check({tag, "_busy"}, PW'(busy), '0);
        check({tag, "_done"}, PW'(done), '0);
        check({tag, "_abrt"}, PW'(aborted), '0);
    endtask

    task automatic run_basic(input string tag);
        gridReady = 1'b1;
        start_sweep(8'd3, {6{32'hA5A5_0001}});
        for (int c = 1; c <= 17; c++) begin
            check($sformatf("%s_valid_c%0d", tag, c), PW'(gridValid),
                  PW'(c == 5 || c == 10 || c == 15));
            check($sformatf("%s_busy_c%0d", tag, c), PW'(busy),
                  PW'(c >= 1 && c <= 16));
            check($sformatf("%s_done_c%0d", tag, c), PW'(done), PW'(c == 16));
            if (c == 16)
                check({tag, "_abrt"}, PW'(aborted), '0);
            if (c == 5 || c == 10 || c == 15)
                check($sformatf("%s_gstep_c%0d", tag, c), PW'(gridStep),
                      PW'(c / 5 - 1));
            tick();
        end
    endtask

    initial begin
        logic [PW-1:0] snap;
        int            offers;
        int            last;
        logic          seen_done;

        RST             = 1'b1;
        start           = 1'b0;
        abort           = 1'b0;
        horizon         = 8'd0;
        stepperPosition = '0;
        gridReady       = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_values("rst");
        RST = 1'b0;
        tick();

        run_basic("s1");

        // Backpressure: ready held low for 7 offered cycles.
        gridReady = 1'b0;
        snap = {6{32'h1234_5678}};
        start_sweep(8'd2, snap);
        for (int c = 1; c <= 19; c++) begin
            gridReady = (c >= 12);
            if (c >= 5 && c <= 12) begin
                check($sformatf("bp_valid_c%0d", c), PW'(gridValid), PW'(1));
                check($sformatf("bp_gstep_c%0d", c), PW'(gridStep), '0);
                check($sformatf("bp_snap_c%0d", c), posSnapshot, snap);
            end else begin
                check($sformatf("bp_valid_c%0d", c), PW'(gridValid),
                      PW'(c == 17));
            end
            if (c == 17)
                check("bp_step1", PW'(gridStep), PW'(1));
            check($sformatf("bp_done_c%0d", c), PW'(done), PW'(c == 18));
            tick();
        end

        // Snapshot freeze and start while busy.
        gridReady = 1'b1;
        start_sweep(8'd2, {{5{32'h0}}, 32'h0000_1000});
        for (int c = 1; c <= 12; c++) begin
            stepperPosition = {6{$urandom()}};
            start   = (c == 3);
            horizon = (c == 3) ? 8'd7 : 8'd2;
            check($sformatf("sf_snap_c%0d", c), PW'(posSnapshot[31:0]),
                  PW'(32'h0000_1000));
            check($sformatf("sf_valid_c%0d", c), PW'(gridValid),
                  PW'(c == 5 || c == 10));
            check($sformatf("sf_done_c%0d", c), PW'(done), PW'(c == 11));
            check($sformatf("sf_busy_c%0d", c), PW'(busy), PW'(c <= 11));
            if (c == 10)
                check("sf_step", PW'(step), PW'(1));
            tick();
        end
        start = 1'b0;

        // Abort during the offer of step 1 with ready high.
        snap = {6{32'hCAFE_0042}};
        start_sweep(8'd5, snap);
        for (int c = 1; c <= 25; c++) begin
            abort = (c == 10);
            if (c == 10) begin
                check("ab_valid_pre", PW'(gridValid), PW'(1));
                check("ab_gstep_pre", PW'(gridStep), PW'(1));
            end
            if (c == 11) begin
                check("ab_done", PW'(done), PW'(1));
                check("ab_abrt", PW'(aborted), PW'(1));
                check("ab_step", PW'(step), '0);
                check("ab_busy", PW'(busy), '0);
                check("ab_snap", posSnapshot, snap);
            end
            if (c >= 11)
                check($sformatf("ab_valid_c%0d", c), PW'(gridValid), '0);
            if (c >= 12)
                check($sformatf("ab_done_c%0d", c), PW'(done), '0);
            tick();
        end
        abort = 1'b0;

        // Abort and start together in IDLE: no sweep.
        start   = 1'b1;
        abort   = 1'b1;
        horizon = 8'd3;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", PW'(busy), '0);
        check("sa_done", PW'(done), '0);
        tick();
        check("sa_busy2", PW'(busy), '0);

        // Zero horizon: done pulse only.
        start_sweep(8'd0, '1);
        check("h0_done", PW'(done), PW'(1));
        check("h0_abrt", PW'(aborted), '0);
        check("h0_busy", PW'(busy), '0);
        check("h0_valid", PW'(gridValid), '0);
        tick();
        check("h0_done2", PW'(done), '0);

        // Full horizon of 255 steps.
        offers    = 0;
        last      = -1;
        seen_done = 1'b0;
        start_sweep(8'd255, {6{32'h0BAD_F00D}});
        for (int c = 1; c < 1400 && !seen_done; c++) begin
            if (gridValid) begin
                check($sformatf("h255_gstep_%0d", offers), PW'(gridStep),
                      PW'(offers));
                last = int'(gridStep);
                offers++;
            end
            if (done) begin
                seen_done = 1'b1;
                check("h255_done_c", PW'(c), PW'(1276));
            end
            tick();
        end
        check("h255_seen_done", PW'(seen_done), PW'(1));
        check("h255_offers", PW'(offers), PW'(255));
        check("h255_last", PW'(last), PW'(254));
        tick();

        // Reset in SETTLE of step 3, then a fresh sweep.
        gridReady = 1'b1;
        start_sweep(8'd5, {6{32'h7777_8888}});
        repeat (16) tick();
        check("rs_step3", PW'(step), PW'(3));
        check("rs_busy", PW'(busy), PW'(1));
        #1 RST = 1'b1;
        #1;
        check_reset_values("rs_async");
        tick();
        check("rs_done_hold", PW'(done), '0);
        RST = 1'b0;
        tick();
        check("rs_idle_done", PW'(done), '0);
        run_basic("s6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
